// File: rtl/des_round_core_pkg.sv
// Shared DES definitions: round count, FSM encoding, FIPS 46-3 permutation and S-box tables.
// All tables use bit 1 = MSB numbering; entries are 1-based source bit positions.
package des_round_core_pkg;

   localparam int unsigned DES_ROUNDS = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } des_state_e;

   typedef struct packed {
      logic [31:0] l;
      logic [31:0] r;
   } des_half_t;

   localparam int unsigned IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,
      60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,
      64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,
      59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,
      63, 55, 47, 39, 31, 23, 15, 7};

   localparam int unsigned FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,
      39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,
      37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,
      35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,
      33, 1, 41,  9, 49, 17, 57, 25};

   localparam int unsigned E_T [48] = '{
      32,  1,  2,  3,  4,  5,
       4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,
      12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,
      20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,
      28, 29, 30, 31, 32,  1};

   localparam int unsigned P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25};

   // Indexed [box][row*16 + col]
   localparam int unsigned SBOX [8][64] = '{
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

endpackage

// File: rtl/des_f_func.sv
// DES Feistel function f(R, K): expansion, key mix, S-box substitution, P permutation.
module des_f_func
   import des_round_core_pkg::*;
(
   input  logic [31:0] r,
   input  logic [47:0] k,
   output logic [31:0] f
);

   always_comb begin
      logic [47:0] x;
      logic [31:0] s;
      logic [5:0]  six;
      x   = '0;
      s   = '0;
      six = '0;
      f   = '0;
      for (int i = 0; i < 48; i++)
         x[6'(47 - i)] = r[5'(32 - int'(E_T[6'(i)]))];
      x = x ^ k;
      // S1 lands in the top nibble after all eight shifts
      for (int b = 0; b < 8; b++) begin
         six = 6'(x >> (42 - 6 * b));
         s   = {s[27:0], 4'(SBOX[3'(b)][{six[5], six[0], six[4:1]}])};
      end
      for (int i = 0; i < 32; i++)
         f[5'(31 - i)] = s[5'(32 - int'(P_T[5'(i)]))];
   end

endmodule

// File: rtl/des_round_core.sv
// Iterative DES datapath: one Feistel round per cycle, subkeys supplied externally per rnd.
// Accepts one block in IDLE, runs ROUNDS rounds, presents FP(R16,L16) with valid/ready.
module des_round_core
   import des_round_core_pkg::*;
#(
   parameter int unsigned ROUNDS = DES_ROUNDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        encrypt,
   input  logic [63:0] din,
   output logic [4:0]  rnd,
   output logic        rnd_encrypt,
   input  logic [47:0] subkey,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] dout
);

   localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++)
         y[6'(63 - i)] = x[6'(64 - int'(IP_T[6'(i)]))];
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++)
         y[6'(63 - i)] = x[6'(64 - int'(FP_T[6'(i)]))];
      return y;
   endfunction

   des_state_e  state, state_d;
   des_half_t   lr, lr_d;
   logic [4:0]  rnd_d;
   logic        enc_d;
   logic        ready_d;
   logic        ov_d;
   logic [63:0] dout_d;
   logic [31:0] f_out;

   des_f_func u_f (
      .r (lr.r),
      .k (subkey),
      .f (f_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         lr          <= '0;
         rnd         <= '0;
         rnd_encrypt <= 1'b1;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         dout        <= '0;
      end else begin
         state       <= state_d;
         lr          <= lr_d;
         rnd         <= rnd_d;
         rnd_encrypt <= enc_d;
         in_ready    <= ready_d;
         out_valid   <= ov_d;
         dout        <= dout_d;
      end
   end

   always_comb begin
      state_d = state;
      lr_d    = lr;
      rnd_d   = rnd;
      enc_d   = rnd_encrypt;
      ov_d    = out_valid;
      dout_d  = dout;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               lr_d    = des_half_t'(ip_perm(din));
               enc_d   = encrypt;
               rnd_d   = '0;
               state_d = ROUND;
            end
         end
         ROUND: begin
            lr_d.l = lr.r;
            lr_d.r = lr.l ^ f_out;
            if (rnd == LAST_RND) begin
               rnd_d   = '0;
               state_d = DONE;
            end else begin
               rnd_d = rnd + 5'd1;
            end
         end
         DONE: begin
            // First DONE cycle registers the result; later cycles wait for the handshake
            if (!out_valid) begin
               ov_d   = 1'b1;
               dout_d = fp_perm({lr.r, lr.l});
            end else if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

endmodule

// File: tb/tb_des_round_core.sv
// Scoreboarded bench for des_round_core with a behavioural DES key schedule as subkey source.
module tb_des_round_core;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32};

   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // {key, plaintext, ciphertext}
   localparam int NVEC = 11;
   localparam logic [191:0] VECS [NVEC] = '{
      {64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405},
      {64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7},
      {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58},
      {64'h3000000000000000, 64'h1000000000000001, 64'h958E6E627A05557B},
      {64'h1111111111111111, 64'h1111111111111111, 64'hF40379AB9E0EC533},
      {64'h0123456789ABCDEF, 64'h1111111111111111, 64'h17668DFC7292532D},
      {64'h1111111111111111, 64'h0123456789ABCDEF, 64'h8A5AE1F81AB8F2DD},
      {64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'hED39D950FA74BCC4},
      {64'h7CA110454A1A6E57, 64'h01A1D6D039776742, 64'h690F5B0D9A26939B},
      {64'h0131D9619DC1376E, 64'h5CD54CA83DEF57DA, 64'h7A389D10354BD271},
      {64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000}};

   typedef struct {
      logic [63:0] val;
      bit          chk;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        encrypt;
   logic [63:0] din;
   logic [4:0]  rnd;
   logic        rnd_encrypt;
   logic [47:0] subkey;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] dout;

   logic [47:0] ks [16];
   logic [3:0]  ri;
   exp_t        exp_q [$];
   int          lat_q [$];
   int          cyc;
   int          checks;
   int          errors;
   int          outcnt;
   logic [63:0] last_out;
   logic        ov_prev;

   des_round_core #(.ROUNDS(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .encrypt     (encrypt),
      .din         (din),
      .rnd         (rnd),
      .rnd_encrypt (rnd_encrypt),
      .subkey      (subkey),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .dout        (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Combinational subkey source: forward schedule for encrypt, reversed for decrypt
   always_comb begin
      ri     = 4'(rnd);
      subkey = rnd_encrypt ? ks[ri] : ks[4'd15 - ri];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   task automatic make_ks(input logic [63:0] key);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [55:0] cdr;
      for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[6'(i)])];
      c = cd[55:28];
      d = cd[27:0];
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < SHIFTS[4'(r)]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cdr = {c, d};
         for (int i = 0; i < 48; i++) ks[4'(r)][6'(47 - i)] = cdr[6'(56 - PC2[6'(i)])];
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the acceptance edge
   task automatic send(input logic [63:0] d, input logic e, input logic [63:0] req,
                       input bit c, input string nm);
      exp_t x;
      int   n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) fail_now({nm, " accept_timeout"});
      in_valid = 1'b1;
      din      = d;
      encrypt  = e;
      x.val    = req;
      x.chk    = c;
      x.name   = nm;
      exp_q.push_back(x);
      @(posedge clk); #1;
      lat_q.push_back(cyc);
      in_valid = 1'b0;
      din      = {$urandom, $urandom};
      encrypt  = ~e;
   endtask

   task automatic wait_out(input string nm);
      int start;
      int n;
      start = outcnt;
      n     = 0;
      while (outcnt == start && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (outcnt == start) fail_now({nm, " output_timeout"});
   endtask

   // Monitor: latency on out_valid rise, value on handshake
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && !ov_prev) begin
            if (lat_q.size() == 0) fail_now("unexpected_out_valid");
            else chk("latency", 64'(cyc - lat_q.pop_front()), 64'd17);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_output");
            end else begin
               e = exp_q.pop_front();
               if (e.chk) chk(e.name, dout, e.val);
            end
            last_out = dout;
            outcnt++;
         end
      end
      ov_prev = out_valid;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [191:0] v;
      logic [63:0]  pt, ct, key;
      cyc       = 0;
      checks    = 0;
      errors    = 0;
      outcnt    = 0;
      last_out  = '0;
      ov_prev   = 1'b0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      encrypt   = 1'b0;
      din       = 64'hDEADBEEFCAFEF00D;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) ks[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_rnd", 64'(rnd), 64'd0);
      chk("rst_rnd_encrypt", 64'(rnd_encrypt), 64'd1);
      rst_n = 1'b1;

      // Directed vectors: first accept lands on the first edge after release
      for (int i = 0; i < NVEC; i++) begin
         v = VECS[i];
         make_ks(v[191:128]);
         send(v[127:64], 1'b1, v[63:0], 1'b1, $sformatf("enc_vec%0d", i));
         if (i == 0) begin
            chk("busy_in_ready", 64'(in_ready), 64'd0);
            chk("busy_rnd_encrypt", 64'(rnd_encrypt), 64'd1);
         end
         wait_out($sformatf("enc_vec%0d", i));
         send(v[63:0], 1'b0, v[127:64], 1'b1, $sformatf("dec_vec%0d", i));
         if (i == 0) chk("dec_rnd_encrypt", 64'(rnd_encrypt), 64'd0);
         wait_out($sformatf("dec_vec%0d", i));
      end
      chk("idle_rnd", 64'(rnd), 64'd0);
      chk("held_rnd_encrypt", 64'(rnd_encrypt), 64'd0);

      // Backpressure in DONE with a stray in_valid pulse
      make_ks(64'h133457799BBCDFF1);
      out_ready = 1'b0;
      send(64'h0123456789ABCDEF, 1'b1, 64'h85E813540F0AB405, 1'b1, "hold_result");
      for (int n = 0; n < 40 && !out_valid; n++) begin
         @(posedge clk); #1;
      end
      for (int n = 0; n < 5; n++) begin
         chk("hold_out_valid", 64'(out_valid), 64'd1);
         chk("hold_dout", dout, 64'h85E813540F0AB405);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_rnd", 64'(rnd), 64'd0);
         in_valid = (n == 2);
         din      = 64'hFFFFFFFFFFFFFFFF;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_out("hold_result");

      // Reset mid-round discards the block in flight
      make_ks(64'h0000000000000000);
      send(64'h0000000000000000, 1'b0, 64'h0, 1'b0, "rst_victim");
      for (int n = 0; n < 40 && rnd != 5'd8; n++) begin
         @(posedge clk); #1;
      end
      chk("rst_reach_rnd8", 64'(rnd), 64'd8);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_dout", dout, 64'd0);
      chk("midrst_rnd", 64'(rnd), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_rnd_encrypt", 64'(rnd_encrypt), 64'd1);
      exp_q.delete();
      lat_q.delete();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send(64'h0000000000000000, 1'b1, 64'h8CA64DE9C1B123A7, 1'b1, "post_rst");
      wait_out("post_rst");

      // Random encrypt/decrypt round trips
      for (int i = 0; i < 200; i++) begin
         key = {$urandom, $urandom};
         pt  = {$urandom, $urandom};
         make_ks(key);
         send(pt, 1'b1, 64'h0, 1'b0, "rt_enc");
         wait_out("rt_enc");
         ct = last_out;
         send(ct, 1'b0, pt, 1'b1, $sformatf("rt_dec%0d", i));
         wait_out("rt_dec");
      end

      repeat (30) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("final_out_valid", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/des_round_core.md
DES_ROUND_CORE -- requirements
Module: des_round_core

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 16, giving the number of Feistel rounds; only the value 16 is legal for standards-compliant DES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, which is high when a block is offered on din.
REQ-005 The block SHALL have port in_ready, output, 1, which is high when the core can accept a block.
REQ-006 The block SHALL have port encrypt, input, 1, selecting encryption (1) or decryption (0); it is sampled together with din.
REQ-007 The block SHALL have port din, input, 64, the plaintext or ciphertext block, MSB-first bit numbering [1:64].
REQ-008 The block SHALL have port rnd, output, 5, the current round index driven to the subkey generator.
REQ-009 The block SHALL have port rnd_encrypt, output, 1, the latched encrypt flag driven to the subkey generator.
REQ-010 The block SHALL have port subkey, input, 48, the round key for rnd, valid combinationally in the same cycle that rnd is driven.
REQ-011 The block SHALL have port out_valid, output, 1, which is high when dout holds a result.
REQ-012 The block SHALL have port out_ready, input, 1, which is high when the downstream can take the result.
REQ-013 The block SHALL have port dout, output, 64, the result block, [1:64].

Function
REQ-014 The block SHALL use FSM states IDLE, ROUND and DONE.
REQ-015 In IDLE the block SHALL assert in_ready=1.
REQ-016 When in_valid&&in_ready, the block SHALL latch IP(din) into L/R and latch encrypt, set rnd=0, and go to ROUND.
REQ-017 In ROUND, each cycle the block SHALL compute L'=R and R'=L xor f(R,subkey), and increment rnd.
REQ-018 After the round with rnd=ROUNDS-1, the block SHALL go to DONE without swapping L/R a further time.
REQ-019 On entry to DONE the block SHALL register dout=FP(R16,L16) (pre-output swap) and set out_valid=1.
REQ-020 Latency SHALL be 17 cycles: acceptance at edge N, out_valid high after edge N+17.
REQ-021 The block SHALL hold dout and out_valid stable in DONE until out_ready=1.
REQ-022 On out_valid&&out_ready, the block SHALL clear out_valid and return to IDLE.
REQ-023 in_ready SHALL be 0 in ROUND and DONE, so no back-to-back overlap is allowed and throughput is 1 block per ≥18 cycles.
REQ-024 encrypt and din changes outside the acceptance cycle SHALL have no effect.
REQ-025 rnd SHALL be held at 0 in IDLE and DONE; rnd_encrypt SHALL be held at the latched value until the next acceptance.
REQ-026 The core SHALL NOT perform any key rotation itself; round-direction handling (left shifts for encrypt, right shifts for decrypt, no shift at round 0 for decrypt) belongs to the subkey generator fed by rnd/rnd_encrypt.
REQ-027 Bit-level permutations (IP, FP, E, P) and the S-box lookup SHALL follow FIPS 46-3 with bit 1 as the MSB.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force: state=IDLE, in_ready=1 after release, out_valid=0, dout=0, rnd=0, rnd_encrypt=1, L=R=0.
REQ-029 A reset asserted mid-ROUND or in DONE SHALL discard the block in flight with no partial output.
REQ-030 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 The shared DES package SHALL hold the IP/FP/E/P permutation tables, the S-box tables, the FSM state encoding and the ROUNDS default.
REQ-032 The Feistel function SHALL be one combinational sub-module, des_f_func (R[1:32], K[1:48] -> f[1:32]); IP/FP and the FSM SHALL stay in des_round_core.

Verification
REQ-033 Paired with des_subkeys_gen, key 133457799BBCDFF1, encrypt=1, din 0123456789ABCDEF -> dout 85E813540F0AB405 with out_valid 17 cycles after acceptance.
REQ-034 Key 133457799BBCDFF1, encrypt=0, din 85E813540F0AB405 -> dout 0123456789ABCDEF.
REQ-035 Key 0000000000000000, din 0000000000000000, encrypt=1 -> dout 8CA64DE9C1B123A7.
REQ-036 Holding out_ready=0 for 5 cycles in DONE -> dout and out_valid stable, in_ready=0, and a second in_valid pulse is ignored.
REQ-037 rst_n pulsed low at round 8 -> out_valid=0 and dout=0 at once; the next block is processed correctly from scratch.
REQ-038 Random 200-block encrypt-then-decrypt round trip -> every block equals the original.
